// File: rtl/imem_loader_if.sv
// Host byte stream and instruction-memory write port of the loader.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [19:0] imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed stream of 20-bit instruction words into instruction memory,
// holding the CPU in reset until the whole program has been written.
module imem_loader #(
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          fmt_err,
  output logic [15:0]   words_loaded
);

  localparam logic [16:0] DepthW = 17'(IMEM_DEPTH);

  typedef enum logic [3:0] {
    StIdle, StLen0, StLen1, StByte0, StByte1, StByte2, StWrite, StDone, StErr
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_lo_q, b0_q, b1_q;
  logic [15:0] len_q, words_q, addr_q;
  logic [19:0] wdata_q;
  logic        fmt_err_q;

  logic        xfer, start_ok;
  logic [15:0] len_in;

  assign len_in   = {bus.in_data, len_lo_q};
  assign xfer     = bus.in_valid && bus.in_ready;
  assign start_ok = start && (state_q inside {StIdle, StDone, StErr});

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: if (start) state_d = StLen0;
      StLen0:  if (xfer) state_d = StLen1;
      StLen1: begin
        if (xfer) begin
          if (len_in == 16'd0)                state_d = StDone;
          else if ({1'b0, len_in} > DepthW)   state_d = StErr;
          else                                state_d = StByte0;
        end
      end
      StByte0: if (xfer) state_d = StByte1;
      StByte1: if (xfer) state_d = StByte2;
      StByte2: if (xfer) state_d = StWrite;
      StWrite: state_d = (words_q + 16'd1 == len_q) ? StDone : StByte0;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready = state_q inside {StLen0, StLen1, StByte0, StByte1, StByte2};
    bus.imem_we  = (state_q == StWrite);
    busy         = state_q inside {StLen0, StLen1, StByte0, StByte1, StByte2, StWrite};
    done         = (state_q == StDone);
    err          = (state_q == StErr);
    cpu_hold     = (state_q != StDone);
  end

  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign fmt_err        = fmt_err_q;
  assign words_loaded   = words_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      len_lo_q  <= '0;
      len_q     <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      words_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      fmt_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        words_q   <= '0;
        fmt_err_q <= 1'b0;
      end
      // Address/data are captured on the last byte so they hold between writes.
      if (xfer) begin
        unique case (state_q)
          StLen0:  len_lo_q <= bus.in_data;
          StLen1:  len_q    <= len_in;
          StByte0: b0_q     <= bus.in_data;
          StByte1: b1_q     <= bus.in_data;
          StByte2: begin
            addr_q  <= words_q;
            wdata_q <= {bus.in_data[3:0], b1_q, b0_q};
            if (bus.in_data[7:4] != 4'd0) fmt_err_q <= 1'b1;
          end
          default: ;
        endcase
      end
      if (state_q == StWrite) words_q <= words_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level reference model.
module tb_imem_loader;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cpu_hold, busy, done, err, fmt_err;
  logic [15:0] words_loaded;

  imem_loader_if bus ();

  imem_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .fmt_err      (fmt_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  bit ready_in_write = 1'b0;
  bit bad_addr = 1'b0;
  logic [19:0] tb_mem [DEPTH];
  logic [23:0] prog [$];

  // Memory model fed by observed write strobes.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_cnt <= wr_cnt + 1;
      if (bus.imem_addr < 16'(DEPTH)) tb_mem[bus.imem_addr] <= bus.imem_wdata;
      else bad_addr <= 1'b1;
      if (bus.in_ready !== 1'b0) ready_in_write <= 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic drive_byte(input logic [7:0] b, input bit gaps, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      bus.in_data  = b;
      bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      start        = gaps && ($urandom_range(0, 7) == 0);
      #1;
      if (bus.in_valid && bus.in_ready) ok = 1'b1;
      @(posedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s byte_accept: actual=not accepted required=accepted within 200 cycles",
               name);
    end
  endtask

  task automatic start_session(input string name);
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, cpu_hold, done, err, fmt_err, bus.in_ready, words_loaded} !==
        {6'b110001, 16'd0}) begin
      failures++;
      $display("FAIL %s after_start: actual busy/hold/done/err/fmt/rdy=%b%b%b%b%b%b wl=%0d required=110001 wl=0",
               name, busy, cpu_hold, done, err, fmt_err, bus.in_ready, words_loaded);
    end
  endtask

  // Sends a session with length field n_field; words come from prog.
  task automatic load(input string name, input int n_field, input bit gaps);
    logic [15:0] n;
    int base;
    int exp_writes;
    bit exp_fmt = 1'b0;
    logic [23:0] raw;
    n = 16'(n_field);
    base = wr_cnt;
    start_session(name);
    drive_byte(n[7:0], gaps, name);
    drive_byte(n[15:8], gaps, name);
    if (n == 16'd0 || int'(n) > int'(DEPTH)) begin
      exp_writes = 0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      start = 1'b0;
      checks++;
      if (n == 16'd0) begin
        if ({done, err, busy, cpu_hold, words_loaded} !== {4'b1000, 16'd0}) begin
          failures++;
          $display("FAIL %s len_zero: actual done/err/busy/hold=%b%b%b%b wl=%0d required=1000 wl=0",
                   name, done, err, busy, cpu_hold, words_loaded);
        end
      end else begin
        if ({done, err, busy, cpu_hold} !== 4'b0101) begin
          failures++;
          $display("FAIL %s len_too_big: actual done/err/busy/hold=%b%b%b%b required=0101",
                   name, done, err, busy, cpu_hold);
        end
      end
    end else begin
      exp_writes = int'(n);
      for (int i = 0; i < int'(n); i++) begin
        raw = prog[i];
        drive_byte(raw[7:0], gaps, name);
        drive_byte(raw[15:8], gaps, name);
        drive_byte(raw[23:16], gaps, name);
        if (raw[23:20] != 4'd0) exp_fmt = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        start = 1'b0;
        checks++;
        if (bus.imem_we !== 1'b1 || bus.in_ready !== 1'b0 || bus.imem_addr !== 16'(i) ||
            bus.imem_wdata !== raw[19:0]) begin
          failures++;
          $display("FAIL %s write[%0d]: actual we=%b rdy=%b addr=%0d data=%05h required we=1 rdy=0 addr=%0d data=%05h",
                   name, i, bus.imem_we, bus.in_ready, bus.imem_addr, bus.imem_wdata, i, raw[19:0]);
        end
      end
      @(negedge clk);
      checks++;
      if ({done, err, busy, cpu_hold, fmt_err} !== {4'b1000, exp_fmt} || words_loaded !== n) begin
        failures++;
        $display("FAIL %s final: actual done/err/busy/hold/fmt=%b%b%b%b%b wl=%0d required=1000%b wl=%0d",
                 name, done, err, busy, cpu_hold, fmt_err, words_loaded, exp_fmt, n);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cnt - base != exp_writes || bus.imem_we !== 1'b0) begin
      failures++;
      $display("FAIL %s write_count: actual=%0d we=%b required=%0d we=0",
               name, wr_cnt - base, bus.imem_we, exp_writes);
    end
  endtask

  task automatic fill_prog(input int n, input bit bad_pad);
    logic [3:0] pad;
    prog.delete();
    for (int i = 0; i < n; i++) begin
      pad = bad_pad ? 4'($urandom_range(1, 15)) : 4'd0;
      prog.push_back({pad, 20'($urandom)});
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({bus.in_ready, bus.imem_we, cpu_hold, busy, done, err, fmt_err} !== 7'b0010000 ||
        bus.imem_addr !== 16'd0 || bus.imem_wdata !== 20'd0 || words_loaded !== 16'd0) begin
      failures++;
      $display("FAIL %s reset_values: actual rdy/we/hold/busy/done/err/fmt=%b%b%b%b%b%b%b addr=%0d data=%05h wl=%0d required=0010000 addr=0 data=00000 wl=0",
               name, bus.in_ready, bus.imem_we, cpu_hold, busy, done, err, fmt_err,
               bus.imem_addr, bus.imem_wdata, words_loaded);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    prog.delete();
    prog.push_back(24'h051234);
    prog.push_back(24'h0FABCD);
    load("basic", 2, 1'b0);
    checks++;
    if (tb_mem[0] !== 20'h51234 || tb_mem[1] !== 20'hFABCD) begin
      failures++;
      $display("FAIL basic mem: actual=%05h,%05h required=51234,fabcd", tb_mem[0], tb_mem[1]);
    end
  endtask

  task automatic test_backpressure();
    prog.delete();
    prog.push_back(24'h051234);
    prog.push_back(24'h0FABCD);
    load("backpressure", 2, 1'b1);
    checks++;
    if (ready_in_write) begin
      failures++;
      $display("FAIL backpressure ready_in_write: actual=1 required=0");
    end
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, DEPTH);
      fill_prog(n, 1'b0);
      load("random", n, bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_boundaries();
    load("n_zero", 0, 1'b0);
    load("n_over", DEPTH + 1, 1'b0);
    fill_prog(DEPTH, 1'b0);
    load("n_depth", DEPTH, 1'b1);
    checks++;
    if (tb_mem[DEPTH-1] !== prog[DEPTH-1][19:0] || bad_addr) begin
      failures++;
      $display("FAIL n_depth last_word: actual=%05h bad_addr=%b required=%05h bad_addr=0",
               tb_mem[DEPTH-1], bad_addr, prog[DEPTH-1][19:0]);
    end
  endtask

  task automatic test_pad();
    prog.delete();
    prog.push_back(24'hF3BEEF);
    prog.push_back(24'h012345);
    load("pad", 2, 1'b0);
    repeat (5) @(negedge clk);
    checks++;
    if (fmt_err !== 1'b1 || tb_mem[0] !== 20'h3BEEF) begin
      failures++;
      $display("FAIL pad sticky: actual fmt=%b mem0=%05h required fmt=1 mem0=3beef",
               fmt_err, tb_mem[0]);
    end
  endtask

  task automatic test_reset_mid();
    fill_prog(2, 1'b0);
    start_session("reset_mid");
    drive_byte(8'd2, 1'b0, "reset_mid");
    drive_byte(8'd0, 1'b0, "reset_mid");
    drive_byte(prog[0][7:0], 1'b0, "reset_mid");
    drive_byte(prog[0][15:8], 1'b0, "reset_mid");
    drive_byte(prog[0][23:16], 1'b0, "reset_mid");
    drive_byte(prog[1][7:0], 1'b0, "reset_mid");
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("reset_mid");
    rst_n = 1'b1;
    fill_prog(3, 1'b0);
    load("after_reset", 3, 1'b1);
  endtask

  task automatic test_restart();
    fill_prog(4, 1'b0);
    load("restart_a", 4, 1'b0);
    fill_prog(2, 1'b0);
    load("restart_b", 2, 1'b0);
    checks++;
    if (tb_mem[0] !== prog[0][19:0] || tb_mem[1] !== prog[1][19:0]) begin
      failures++;
      $display("FAIL restart overwrite: actual=%05h,%05h required=%05h,%05h",
               tb_mem[0], tb_mem[1], prog[0][19:0], prog[1][19:0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_boundaries();
    test_pad();
    test_reset_mid();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IMEM_DEPTH, default 256: number of 20-bit instruction words in the target instruction memory; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; begins a load session. Honoured only in IDLE, DONE or ERR.
REQ-005 in_data  input  8  byte stream from host.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader accepts a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe.
REQ-009 imem_addr  output  16  instruction-memory word address.
REQ-010 imem_wdata  output  20  instruction word to write.
REQ-011 cpu_hold  output  1  holds the CPU (pc and register file) in reset while high.
REQ-012 busy  output  1  load session in progress.
REQ-013 done  output  1  program fully loaded.
REQ-014 err  output  1  session aborted on bad length.
REQ-015 fmt_err  output  1  sticky flag: nonzero pad nibble seen.
REQ-016 words_loaded  output  16  count of words written this session.

Function
REQ-017 States: IDLE, LEN0, LEN1, BYTE0, BYTE1, BYTE2, WRITE, DONE, ERR.
REQ-018 in_ready is high exactly in LEN0, LEN1, BYTE0, BYTE1 and BYTE2. A byte transfers on a rising edge with in_valid && in_ready. in_valid without in_ready is ignored; no byte is lost or duplicated.
REQ-019 IDLE/DONE/ERR + start: go to LEN0; clear words_loaded and fmt_err; cpu_hold=1.
REQ-020 Stream format: 16-bit word count N, little-endian (LEN0 = low byte, LEN1 = high byte), then N words of 3 bytes each, little-endian.
REQ-021 LEN1 transfer, decided on the same edge: N==0 -> DONE; N>IMEM_DEPTH -> ERR; otherwise BYTE0.
REQ-022 Word assembly: word = {b2[3:0], b1, b0}. If b2[7:4]!=0, discard the nibble and set fmt_err; the write still occurs.
REQ-023 BYTE2 transfer -> WRITE. In WRITE, for exactly one cycle: imem_we=1, imem_addr=words_loaded, imem_wdata=word. words_loaded increments at the end of WRITE.
REQ-024 Latency: last byte of a word accepted on edge k; imem_we high in the cycle following edge k. Sustained throughput is one word per 4 cycles.
REQ-025 WRITE exit: words_loaded+1==N -> DONE; else BYTE0.
REQ-026 imem_we=0 outside WRITE. imem_addr and imem_wdata hold their last values outside WRITE.
REQ-027 busy=1 in LEN0..WRITE. done=1 only in DONE. err=1 only in ERR.
REQ-028 cpu_hold=1 in every state except DONE. cpu_hold falls on the edge entering DONE.
REQ-029 start while busy is ignored. start on the same edge as a byte transfer in a non-accepting state has no effect.
REQ-030 imem_addr never exceeds IMEM_DEPTH-1; REQ-021 guarantees this, and no wrap-around occurs.

Reset
REQ-031 rst_n low at a rising edge forces, on that edge: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, err=0, fmt_err=0, words_loaded=0.
REQ-032 Reset mid-session (including during WRITE) abandons the session. No write strobe is issued in the reset cycle.

Verification
REQ-033 Basic load: start; bytes 02,00, 34,12,05, CD,AB,0F with in_valid always high -> writes (0,0x51234) then (1,0xFABCD); done=1, cpu_hold=0, words_loaded=2.
REQ-034 Backpressure: same stream with in_valid toggled randomly -> identical writes. in_ready is never high in WRITE.
REQ-035 Boundaries: N=0 -> DONE directly, no imem_we. N=IMEM_DEPTH+1 -> ERR after LEN1, cpu_hold=1, err=1. N=IMEM_DEPTH -> last write at addr IMEM_DEPTH-1.
REQ-036 Pad nibble: third byte 0xF3 -> bits [19:16]=3, fmt_err=1 until the next start.
REQ-037 Reset in BYTE1 of word 1 -> IDLE next edge with all REQ-031 values. A new start plus a full stream then loads correctly.
REQ-038 Restart from DONE: start -> cpu_hold=1, done=0, words_loaded=0; second program overwrites from addr 0.
